axis_block_bridge: RTL and testbench
====================================

AXIS_BLOCK_BRIDGE -- requirements
Module: axis_block_bridge

Interface
REQ-001 The block SHALL have parameter BLOCK_BYTES, default 12: bytes per block, legal range 2..32.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = first byte maps to bits [8*BLOCK_BYTES-1 -: 8]; 0 = first byte maps to [7:0].
REQ-003 The block SHALL have parameter TIMEOUT, default 0: idle cycles before a partial block is pad-flushed; 0 disables flushing.
REQ-004 The block SHALL have parameter PAD_BYTE, default 8'h00: fill value for pad-flushed positions.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port s_byte_tdata / s_byte_tvalid / s_byte_tready, in/in/out, 8/1/1 bits: byte input to the packer.
REQ-008 The block SHALL have port m_block_tdata / m_block_tvalid / m_block_tready, out/out/in, 8*BLOCK_BYTES/1/1 bits: packed block output.
REQ-009 The block SHALL have port m_block_tpad, output, 1 bit: high with m_block_tvalid when the block was pad-flushed.
REQ-010 The block SHALL have port s_block_tdata / s_block_tvalid / s_block_tready, in/in/out, 8*BLOCK_BYTES/1/1 bits: block input to the unpacker.
REQ-011 The block SHALL have port m_byte_tdata / m_byte_tvalid / m_byte_tready / m_byte_tlast, out/out/in/out, 8/1/1/1 bits: unpacked byte output.

Function
REQ-012 Packer and unpacker SHALL be fully independent, sharing only clk and rst_n.
REQ-013 A transfer SHALL occur only on a cycle where tvalid and tready are both high; valid, once asserted, SHALL hold data stable until the transfer completes.
REQ-014 Packer: an assembly register plus byte count (0..BLOCK_BYTES-1) SHALL collect accepted bytes at the positions set by MSB_FIRST.
REQ-015 Packer: an output register SHALL drive m_block_*; when the final byte is accepted, the complete block SHALL be loaded with tpad=0 and appear on m_block_tvalid the following cycle (latency 1); count returns to 0.
REQ-016 Packer: s_byte_tready SHALL be low only when (count==BLOCK_BYTES-1 and m_block_tvalid high) or a flush is pending; it SHALL be derived from registered state only.
REQ-017 Packer: the output register SHALL clear m_block_tvalid on handshake unless it is reloaded the same cycle.
REQ-018 Packer timeout (TIMEOUT>0): an idle counter SHALL reset on every accepted byte and on flush, and increment while count>0 and no byte is accepted.
REQ-019 Packer timeout: when the idle counter reaches TIMEOUT, flush_pending SHALL set.
REQ-020 Packer flush: on the first cycle with flush_pending set and the output register free, unfilled positions SHALL be set to PAD_BYTE and the block loaded with tpad=1; count, idle counter and flush_pending then clear.
REQ-021 Packer: with count==0 no timeout SHALL fire, so an empty block is never emitted.
REQ-022 Unpacker states: IDLE (s_block_tready=1) and SEND; accepting a block SHALL latch it, set index=0 and enter SEND.
REQ-023 Unpacker SEND: m_byte_tvalid=1; m_byte_tdata = byte[index] in MSB_FIRST order; index SHALL advance on each handshake.
REQ-024 Unpacker: m_byte_tlast SHALL be high only when index==BLOCK_BYTES-1; its handshake SHALL return the unpacker to IDLE.
REQ-025 Unpacker throughput SHALL be BLOCK_BYTES+1 cycles per block with no backpressure.
REQ-026 Output backpressure (tready low) SHALL hold all output data and flags stable with no loss or duplication.

Reset
REQ-027 While rst_n is low, all counters, index, flush_pending and data registers SHALL be 0, the unpacker SHALL be in IDLE, and every tvalid, tready, tpad and tlast output SHALL be 0.
REQ-028 Reset assertion SHALL take effect immediately (asynchronous) and discard any partial or in-flight block.
REQ-029 On the first clock edge after rst_n rises, s_byte_tready and s_block_tready SHALL be 1.

Verification
REQ-030 Pack, MSB_FIRST=1, 12 bytes 0x00..0x0B back-to-back, m_block_tready=1 -> one cycle after byte 0x0B: block 0x000102030405060708090A0B, tpad=0, no ready drop.
REQ-031 Pack with m_block_tready=0, 24 bytes -> first block held stable; s_byte_tready drops at count 11 of the second block; releasing ready delivers both blocks in order.
REQ-032 TIMEOUT=8, 5 bytes 0xA1..0xA5 then idle -> 8 idle cycles then block 0xA1A2A3A4A5 followed by 7 x 0x00, tpad=1; no flush with 0 bytes held.
REQ-033 Unpack, MSB_FIRST=0, block 0x0B0A..0100 -> bytes 0x00..0x0B, tlast on 0x0B only; with random m_byte_tready, order preserved and next block accepted only after tlast.
REQ-034 rst_n pulsed low asynchronously mid-block in both paths -> outputs 0 immediately; after release, a fresh 12-byte sequence packs correctly with no leftover bytes.
REQ-035 Loopback (packer output to unpacker input), 1000 random bytes, random backpressure, TIMEOUT=0 -> byte stream out equals byte stream in.

Source files
------------

// File: rtl/axis_block_bridge_if.sv
// axis_block_bridge_if: byte and block stream signals for the packer and unpacker paths.
// slave is the bridge's view, master the view of whatever drives and consumes it.
interface axis_block_bridge_if #(
    parameter int BLOCK_BYTES = 12
);
    logic [7:0]               s_byte_tdata;
    logic                     s_byte_tvalid;
    logic                     s_byte_tready;
    logic [8*BLOCK_BYTES-1:0] m_block_tdata;
    logic                     m_block_tvalid;
    logic                     m_block_tready;
    logic                     m_block_tpad;
    logic [8*BLOCK_BYTES-1:0] s_block_tdata;
    logic                     s_block_tvalid;
    logic                     s_block_tready;
    logic [7:0]               m_byte_tdata;
    logic                     m_byte_tvalid;
    logic                     m_byte_tready;
    logic                     m_byte_tlast;

    modport slave (
        input  s_byte_tdata, s_byte_tvalid, m_block_tready, s_block_tdata, s_block_tvalid, m_byte_tready,
        output s_byte_tready, m_block_tdata, m_block_tvalid, m_block_tpad, s_block_tready,
        output m_byte_tdata, m_byte_tvalid, m_byte_tlast
    );

    modport master (
        output s_byte_tdata, s_byte_tvalid, m_block_tready, s_block_tdata, s_block_tvalid, m_byte_tready,
        input  s_byte_tready, m_block_tdata, m_block_tvalid, m_block_tpad, s_block_tready,
        input  m_byte_tdata, m_byte_tvalid, m_byte_tlast
    );
endinterface

// File: rtl/axis_block_bridge.sv
// axis_block_bridge: byte-to-block packer with optional pad-flush on idle timeout,
// plus an independent block-to-byte unpacker sharing only clock and reset.
module axis_block_bridge #(
    parameter int         BLOCK_BYTES = 12,
    parameter int         MSB_FIRST   = 1,
    parameter int         TIMEOUT     = 0,
    parameter logic [7:0] PAD_BYTE    = 8'h00
) (
    input  logic               clk,
    input  logic               rst_n,
    axis_block_bridge_if.slave bus
);
    localparam int W  = 8 * BLOCK_BYTES;
    localparam int CW = $clog2(BLOCK_BYTES);
    localparam int LW = $clog2(W);
    localparam int IW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(BLOCK_BYTES - 1);

    function automatic logic [LW-1:0] lane(input int k);
        return LW'(MSB_FIRST != 0 ? 8 * (BLOCK_BYTES - 1 - k) : 8 * k);
    endfunction

    typedef enum logic {IDLE, SEND} state_t;

    logic          en_q;
    logic [W-1:0]  asm_q, asm_d, out_q, out_d, asm_w, asm_pad;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          flush_q, flush_d, vld_q, vld_d, pad_q, pad_d;
    logic          acc, out_free, flush_go;
    state_t        st_q, st_d;
    logic [W-1:0]  blk_q, blk_d;
    logic [CW-1:0] idx_q, idx_d;
    logic          brdy_q, brdy_d;

    // en_q keeps both readies low until the first edge after reset release
    assign bus.s_byte_tready  = en_q && !flush_q && !(cnt_q == LAST && vld_q);
    assign acc                = bus.s_byte_tvalid && bus.s_byte_tready;
    assign out_free           = !vld_q || bus.m_block_tready;
    assign flush_go           = flush_q && out_free;
    assign bus.m_block_tdata  = out_q;
    assign bus.m_block_tvalid = vld_q;
    assign bus.m_block_tpad   = vld_q && pad_q;

    always_comb begin
        asm_w = asm_q;
        asm_w[lane(int'(cnt_q)) +: 8] = bus.s_byte_tdata;
        asm_pad = asm_q;
        for (int k = 0; k < BLOCK_BYTES; k++)
            if (k >= int'(cnt_q)) asm_pad[lane(k) +: 8] = PAD_BYTE;
        asm_d   = asm_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        pad_d   = pad_q;
        vld_d   = vld_q && !bus.m_block_tready;
        idle_d  = idle_q;
        flush_d = flush_q;
        if (flush_go) begin
            out_d   = asm_pad;
            vld_d   = 1'b1;
            pad_d   = 1'b1;
            asm_d   = '0;
            cnt_d   = '0;
            idle_d  = '0;
            flush_d = 1'b0;
        end else if (acc) begin
            idle_d = '0;
            asm_d  = cnt_q == LAST ? '0 : asm_w;
            cnt_d  = cnt_q == LAST ? '0 : cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                out_d = asm_w;
                vld_d = 1'b1;
                pad_d = 1'b0;
            end
        end else if (TIMEOUT > 0 && cnt_q != '0 && !flush_q) begin
            idle_d  = idle_q + 1'b1;
            flush_d = idle_d == IW'(TIMEOUT);
        end
    end

    assign bus.s_block_tready = brdy_q;
    assign bus.m_byte_tvalid  = st_q == SEND;
    assign bus.m_byte_tlast   = st_q == SEND && idx_q == LAST;
    assign bus.m_byte_tdata   = blk_q[lane(int'(idx_q)) +: 8];

    always_comb begin
        st_d  = st_q;
        blk_d = blk_q;
        idx_d = idx_q;
        if (st_q == IDLE && bus.s_block_tvalid && brdy_q) begin
            st_d  = SEND;
            blk_d = bus.s_block_tdata;
            idx_d = '0;
        end else if (st_q == SEND && bus.m_byte_tready) begin
            st_d  = idx_q == LAST ? IDLE : SEND;
            idx_d = idx_q == LAST ? '0 : idx_q + 1'b1;
        end
        brdy_d = st_d == IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q    <= 1'b0;
            asm_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
            pad_q   <= 1'b0;
            idle_q  <= '0;
            flush_q <= 1'b0;
            st_q    <= IDLE;
            blk_q   <= '0;
            idx_q   <= '0;
            brdy_q  <= 1'b0;
        end else begin
            en_q    <= 1'b1;
            asm_q   <= asm_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
            pad_q   <= pad_d;
            idle_q  <= idle_d;
            flush_q <= flush_d;
            st_q    <= st_d;
            blk_q   <= blk_d;
            idx_q   <= idx_d;
            brdy_q  <= brdy_d;
        end
    end
endmodule

// File: tb/tb_axis_block_bridge.sv
// tb_axis_block_bridge: directed checks of packing, backpressure, timeout flush,
// unpacking, asynchronous reset and a randomized packer-to-unpacker loopback.
`timescale 1ns/1ps
module tb_axis_block_bridge;
    localparam int BB = 12;
    localparam int W  = 8 * BB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic lb = 1'b0;
    logic pk_rdy = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    axis_block_bridge_if #(.BLOCK_BYTES(BB)) i0 ();
    axis_block_bridge_if #(.BLOCK_BYTES(BB)) i1 ();
    axis_block_bridge_if #(.BLOCK_BYTES(BB)) i2 ();

    // i0's unpacker is either idle or fed straight from i0's packer
    assign i0.m_block_tready = lb ? i0.s_block_tready : pk_rdy;
    assign i0.s_block_tvalid = lb && i0.m_block_tvalid;
    assign i0.s_block_tdata  = i0.m_block_tdata;

    axis_block_bridge #(.BLOCK_BYTES(BB), .MSB_FIRST(1), .TIMEOUT(0), .PAD_BYTE(8'h00))
        u_pk (.clk(clk), .rst_n(rst_n), .bus(i0));
    axis_block_bridge #(.BLOCK_BYTES(BB), .MSB_FIRST(1), .TIMEOUT(8), .PAD_BYTE(8'h00))
        u_to (.clk(clk), .rst_n(rst_n), .bus(i1));
    axis_block_bridge #(.BLOCK_BYTES(BB), .MSB_FIRST(0), .TIMEOUT(0), .PAD_BYTE(8'h00))
        u_up (.clk(clk), .rst_n(rst_n), .bus(i2));

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic put0(input logic [7:0] b, output int w);
        i0.s_byte_tdata  = b;
        i0.s_byte_tvalid = 1'b1;
        w = 0;
        while (!i0.s_byte_tready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) chk("put0_timeout", 1, 0);
        @(negedge clk);
        i0.s_byte_tvalid = 1'b0;
    endtask

    task automatic put1(input logic [7:0] b);
        int w = 0;
        i1.s_byte_tdata  = b;
        i1.s_byte_tvalid = 1'b1;
        while (!i1.s_byte_tready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) chk("put1_timeout", 1, 0);
        @(negedge clk);
        i1.s_byte_tvalid = 1'b0;
    endtask

    task automatic blk2(input logic [W-1:0] d);
        int w = 0;
        i2.s_block_tdata  = d;
        i2.s_block_tvalid = 1'b1;
        while (!i2.s_block_tready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) chk("blk2_timeout", 1, 0);
        @(negedge clk);
        i2.s_block_tvalid = 1'b0;
    endtask

    logic [7:0] src[$];
    logic [7:0] rx[$];
    int         lb_hold = 0;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int w, st, n, k, bad, busy, hold_err, r8;
        logic r, pv, pr, pl;
        logic [7:0] pd, b;
        logic [W-1:0] e1;
        i0.s_byte_tdata = '0; i0.s_byte_tvalid = 1'b0; i0.m_byte_tready = 1'b0;
        i1.s_byte_tdata = '0; i1.s_byte_tvalid = 1'b0; i1.m_block_tready = 1'b1;
        i1.s_block_tdata = '0; i1.s_block_tvalid = 1'b0; i1.m_byte_tready = 1'b0;
        i2.s_byte_tdata = '0; i2.s_byte_tvalid = 1'b0; i2.m_block_tready = 1'b0;
        i2.s_block_tdata = '0; i2.s_block_tvalid = 1'b0; i2.m_byte_tready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_byte_rdy", i0.s_byte_tready, 0);
        chk("rst_blk_rdy", i2.s_block_tready, 0);
        chk("rst_blk_vld", i0.m_block_tvalid, 0);
        chk("rst_blk_data", i0.m_block_tdata, 0);
        chk("rst_byte_vld", i2.m_byte_tvalid, 0);
        chk("rst_tlast", i2.m_byte_tlast, 0);
        chk("rst_tpad", i1.m_block_tpad, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_byte_rdy", i0.s_byte_tready, 1);
        chk("post_rst_blk_rdy", i2.s_block_tready, 1);

        // straight pack, sink always ready
        pk_rdy = 1'b1;
        st = 0;
        for (int i = 0; i < BB; i++) begin
            put0(8'(i), w);
            st += w;
        end
        chk("pk_stall", st, 0);
        chk("pk_vld", i0.m_block_tvalid, 1);
        chk("pk_data", i0.m_block_tdata, 96'h000102030405060708090A0B);
        chk("pk_pad", i0.m_block_tpad, 0);
        @(negedge clk);
        chk("pk_vld_clr", i0.m_block_tvalid, 0);

        // two blocks against a stalled sink
        pk_rdy = 1'b0;
        for (int i = 0; i < 12; i++) put0(8'(8'h20 + i), w);
        e1 = 96'h202122232425262728292A2B;
        hold_err = 0;
        for (int i = 12; i < 23; i++) begin
            put0(8'(8'h20 + i), w);
            if (i0.m_block_tdata !== e1 || i0.m_block_tvalid !== 1'b1) hold_err++;
        end
        chk("bp_hold", hold_err, 0);
        chk("bp_rdy_low", i0.s_byte_tready, 0);
        chk("bp_data1", i0.m_block_tdata, e1);
        pk_rdy = 1'b1;
        @(negedge clk);
        chk("bp_vld_clr", i0.m_block_tvalid, 0);
        chk("bp_rdy_back", i0.s_byte_tready, 1);
        put0(8'h37, w);
        chk("bp_vld2", i0.m_block_tvalid, 1);
        chk("bp_data2", i0.m_block_tdata, 96'h2C2D2E2F3031323334353637);
        @(negedge clk);

        // timeout flush of a 5-byte partial block
        for (int i = 0; i < 5; i++) put1(8'(8'hA1 + i));
        n = 0;
        r8 = 1;
        while (!i1.m_block_tvalid && n < 50) begin
            @(negedge clk);
            n++;
            if (n == 8) r8 = int'(i1.s_byte_tready);
        end
        chk("to_latency", n, 9);
        chk("to_rdy_pending", r8, 0);
        chk("to_data", i1.m_block_tdata, 96'hA1A2A3A4A5_00000000000000);
        chk("to_pad", i1.m_block_tpad, 1);
        @(negedge clk);
        chk("to_vld_clr", i1.m_block_tvalid, 0);
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (i1.m_block_tvalid) n++;
        end
        chk("to_empty", n, 0);

        // LSB-first unpack with random sink readiness
        blk2(96'h0B0A09080706050403020100);
        k = 0; bad = 0; busy = 0; n = 0;
        pv = 1'b0; pr = 1'b0; pd = '0; pl = 1'b0;
        while (k < BB && n < 500) begin
            r = 1'($urandom_range(0, 1));
            i2.m_byte_tready = r;
            if (pv && !pr && (i2.m_byte_tdata !== pd || i2.m_byte_tlast !== pl || !i2.m_byte_tvalid)) bad++;
            if (i2.s_block_tready) busy++;
            if (i2.m_byte_tvalid && r) begin
                chk($sformatf("up_byte%0d", k), i2.m_byte_tdata, k);
                chk($sformatf("up_last%0d", k), i2.m_byte_tlast, k == BB - 1);
                k++;
            end
            pv = i2.m_byte_tvalid; pr = r; pd = i2.m_byte_tdata; pl = i2.m_byte_tlast;
            @(negedge clk);
            n++;
        end
        chk("up_count", k, BB);
        chk("up_stable", bad, 0);
        chk("up_busy", busy, 0);
        chk("up_rdy_after", i2.s_block_tready, 1);

        // unpack throughput with the sink always ready
        i2.m_byte_tready = 1'b1;
        blk2(96'hFFEEDDCCBBAA998877665544);
        n = 1;
        while (!i2.s_block_tready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("up_cycles", n, BB + 1);

        // asynchronous reset mid-block on both paths
        for (int i = 0; i < 5; i++) put0(8'(8'h50 + i), w);
        i2.m_byte_tready = 1'b0;
        blk2(96'h123456789ABCDEF012345678);
        chk("rst_inflight", i2.m_byte_tvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_byte_rdy", i0.s_byte_tready, 0);
        chk("arst_blk_rdy", i2.s_block_tready, 0);
        chk("arst_byte_vld", i2.m_byte_tvalid, 0);
        chk("arst_byte_data", i2.m_byte_tdata, 0);
        chk("arst_blk_vld", i0.m_block_tvalid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < BB; i++) put0(8'(8'h10 + i), w);
        chk("arst_vld", i0.m_block_tvalid, 1);
        chk("arst_data", i0.m_block_tdata, 96'h101112131415161718191A1B);
        @(negedge clk);

        // randomized loopback through i0
        lb = 1'b1;
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    b = 8'($urandom);
                    src.push_back(b);
                    repeat ($urandom_range(0, 1)) @(negedge clk);
                    put0(b, w);
                end
            end
            begin
                logic lr, lpv, lpr;
                logic [7:0] lpd;
                int c = 0;
                lpv = 1'b0; lpr = 1'b0; lpd = '0;
                while (rx.size() < 996 && c < 40000) begin
                    lr = 1'($urandom_range(0, 1));
                    i0.m_byte_tready = lr;
                    if (lpv && !lpr && i0.m_byte_tdata !== lpd) lb_hold++;
                    if (i0.m_byte_tvalid && lr) rx.push_back(i0.m_byte_tdata);
                    lpv = i0.m_byte_tvalid; lpr = lr; lpd = i0.m_byte_tdata;
                    @(negedge clk);
                    c++;
                end
            end
        join
        chk("lb_count", rx.size(), 996);
        bad = 0;
        for (int i = 0; i < rx.size() && i < 996; i++)
            if (rx[i] !== src[i]) bad++;
        chk("lb_data", bad, 0);
        chk("lb_hold", lb_hold, 0);
        i0.m_byte_tready = 1'b1;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (i0.m_byte_tvalid) n++;
        end
        chk("lb_tail", n, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
